// File: rtl/core_pkg.sv
// Shared RV32I core definitions: fetch constants, the F/D pipeline record
// and the next-PC selection encoding used by fetch and the hazard unit.
package core_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR    = 32'h00000013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic            valid;
        logic            misalign;
    } fd_reg_t;

    typedef enum logic [1:0] {
        NPC_SEQ      = 2'd0,
        NPC_HOLD     = 2'd1,
        NPC_REDIRECT = 2'd2
    } npc_sel_e;

    // A resolved branch/jump must never be lost to a load-use stall.
    function automatic npc_sel_e npc_select(input logic pcsrc, input logic stall);
        npc_sel_e sel;
        if (pcsrc) begin
            sel = NPC_REDIRECT;
        end else if (stall) begin
            sel = NPC_HOLD;
        end else begin
            sel = NPC_SEQ;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC mux and the pending misaligned-redirect flag that
// rides along until the first redirected instruction enters Decode.
module fetch_pc_reg
    import core_pkg::*;
#(
    parameter int          XLEN         = core_pkg::XLEN,
    parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pcPlus4F,
    output logic            misalignPend
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic            pend_r;
    logic            pend_next_s;

    assign pcF          = pc_r;
    assign pcPlus4F     = pc_r + XLEN'(32'd4);
    assign misalignPend = pend_r;

    // Next-PC selection and pending misalign flag update.
    always_comb begin
        pc_next_s   = pc_r;
        pend_next_s = pend_r;
        case (npc_select(pcSrcE, stallF))
            NPC_REDIRECT: pc_next_s = {pcTargetE[XLEN-1:2], 2'b00};
            NPC_HOLD:     pc_next_s = pc_r;
            NPC_SEQ:      pc_next_s = pcPlus4F;
            default:      pc_next_s = pc_r;
        endcase
        // The flag is consumed by the D load (or dropped by a flush) of the
        // redirected slot; a fresh redirect always re-arms it.
        if (pcSrcE) begin
            pend_next_s = |pcTargetE[1:0];
        end else if (flushD || !stallD) begin
            pend_next_s = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
    end

    // PC and pending-flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r   <= XLEN'(RESET_VECTOR);
            pend_r <= 1'b0;
        end else begin
            pc_r   <= pc_next_s;
            pend_r <= pend_next_s;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC generation, F/D pipeline register and
// fetch/redirect performance counters.
module fetch_stage
    import core_pkg::*;
#(
    parameter int          XLEN         = core_pkg::XLEN,
    parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    output logic [XLEN-1:0] pcF,
    input  logic [31:0]     instrF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            validD,
    output logic            misalignD,
    output logic [31:0]     fetchCount,
    output logic [31:0]     redirectCount
);

    logic [XLEN-1:0] pc_plus4_s;
    logic            pend_s;
    logic            load_s;
    fd_reg_t         fd_r;
    fd_reg_t         fd_next_s;
    fd_reg_t         bubble_s;
    logic [31:0]     fetch_cnt_r;
    logic [31:0]     redir_cnt_r;

    fetch_pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .pcSrcE       (pcSrcE),
        .pcTargetE    (pcTargetE),
        .pcF          (pcF),
        .pcPlus4F     (pc_plus4_s),
        .misalignPend (pend_s)
    );

    assign load_s   = !flushD && !stallD;
    assign bubble_s = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0, valid: 1'b0, misalign: 1'b0};

    // F/D register next state: flush beats stall beats load.
    always_comb begin
        fd_next_s = fd_r;
        if (flushD) begin
            fd_next_s = bubble_s;
        end else if (stallD) begin
            fd_next_s = fd_r;
        end else begin
            fd_next_s = '{instr: instrF, pc: pcF, pcPlus4: pc_plus4_s,
                          valid: 1'b1, misalign: pend_s};
        end
    end

    // F/D pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_r <= bubble_s;
        end else begin
            fd_r <= fd_next_s;
        end
    end

    // Performance counters, free-running with silent wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_r <= 32'd0;
            redir_cnt_r <= 32'd0;
        end else begin
            fetch_cnt_r <= fetch_cnt_r + (load_s ? 32'd1 : 32'd0);
            redir_cnt_r <= redir_cnt_r + (pcSrcE ? 32'd1 : 32'd0);
        end
    end

    assign instrD        = fd_r.instr;
    assign pcD           = fd_r.pc;
    assign pcPlus4D      = fd_r.pcPlus4;
    assign validD        = fd_r.valid;
    assign misalignD     = fd_r.misalign;
    assign fetchCount    = fetch_cnt_r;
    assign redirectCount = redir_cnt_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a pc-dependent memory model.
module tb_fetch_stage;

    localparam logic [31:0] B   = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stallF, stallD, flushD, pcSrcE;
    logic [31:0] pcTargetE, pcF, instrF, instrD, pcD, pcPlus4D;
    logic        validD, misalignD;
    logic [31:0] fetchCount, redirectCount;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushD        (flushD),
        .pcSrcE        (pcSrcE),
        .pcTargetE     (pcTargetE),
        .pcF           (pcF),
        .instrF        (instrF),
        .instrD        (instrD),
        .pcD           (pcD),
        .pcPlus4D      (pcPlus4D),
        .validD        (validD),
        .misalignD     (misalignD),
        .fetchCount    (fetchCount),
        .redirectCount (redirectCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hA5000000 ^ a;
    endfunction

    always_comb instrF = memw(pcF);

    typedef struct {
        logic        sf, sd, fd, ps;
        logic [31:0] tgt;
        logic [31:0] pcf, instr, pcd;
        logic        vld, mis;
        logic [31:0] fc, rc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sf, sd, fd, ps, input logic [31:0] tgt,
                                input logic [31:0] pcf, instr, pcd,
                                input logic vld, mis, input logic [31:0] fc, rc);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.tgt = tgt;
        v.pcf = pcf; v.instr = instr; v.pcd = pcd;
        v.vld = vld; v.mis = mis; v.fc = fc; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                           input logic [31:0] epd, input logic ev, input logic em,
                           input logic [31:0] efc, input logic [31:0] erc);
        chk({tag, ".pcF"}, pcF, epc);
        chk({tag, ".instrD"}, instrD, ein);
        chk({tag, ".pcD"}, pcD, epd);
        chk({tag, ".pcPlus4D"}, pcPlus4D, ev ? epd + 32'd4 : 32'd0);
        chk({tag, ".validD"}, {31'd0, validD}, {31'd0, ev});
        chk({tag, ".misalignD"}, {31'd0, misalignD}, {31'd0, em});
        chk({tag, ".fetchCount"}, fetchCount, efc);
        chk({tag, ".redirectCount"}, redirectCount, erc);
    endtask

    initial begin
        // sf sd fd ps  target            pcF            instrD               pcD            v  m  fc     rc
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h004, memw(B),          B,             1,0, 32'd1, 32'd0));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h008, memw(B+32'h004),  B+32'h004,     1,0, 32'd2, 32'd0));
        vecs.push_back(mk(1,1,0,0, 32'd0,       B+32'h008, memw(B+32'h004),  B+32'h004,     1,0, 32'd2, 32'd0));
        vecs.push_back(mk(1,1,0,0, 32'd0,       B+32'h008, memw(B+32'h004),  B+32'h004,     1,0, 32'd2, 32'd0));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h00C, memw(B+32'h008),  B+32'h008,     1,0, 32'd3, 32'd0));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h010, memw(B+32'h00C),  B+32'h00C,     1,0, 32'd4, 32'd0));
        vecs.push_back(mk(0,0,1,1, B+32'h100,   B+32'h100, NOP,              32'd0,         0,0, 32'd4, 32'd1));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h104, memw(B+32'h100),  B+32'h100,     1,0, 32'd5, 32'd1));
        vecs.push_back(mk(1,0,1,1, B+32'h042,   B+32'h040, NOP,              32'd0,         0,0, 32'd5, 32'd2));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h044, memw(B+32'h040),  B+32'h040,     1,1, 32'd6, 32'd2));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h048, memw(B+32'h044),  B+32'h044,     1,0, 32'd7, 32'd2));
        vecs.push_back(mk(0,1,1,0, 32'd0,       B+32'h04C, NOP,              32'd0,         0,0, 32'd7, 32'd2));
        vecs.push_back(mk(1,1,0,0, 32'd0,       B+32'h04C, NOP,              32'd0,         0,0, 32'd7, 32'd2));
        vecs.push_back(mk(0,0,0,1, 32'hFFFFFFFC,32'hFFFFFFFC, memw(B+32'h04C), B+32'h04C,   1,0, 32'd8, 32'd3));
        vecs.push_back(mk(0,0,0,0, 32'd0,       32'd0,     memw(32'hFFFFFFFC), 32'hFFFFFFFC, 1,0, 32'd9, 32'd3));
        vecs.push_back(mk(1,1,1,1, B+32'h200,   B+32'h200, NOP,              32'd0,         0,0, 32'd9, 32'd4));
        vecs.push_back(mk(0,0,1,1, B+32'h203,   B+32'h200, NOP,              32'd0,         0,0, 32'd9, 32'd5));
        vecs.push_back(mk(0,0,1,0, 32'd0,       B+32'h204, NOP,              32'd0,         0,0, 32'd9, 32'd5));
        vecs.push_back(mk(0,0,0,0, 32'd0,       B+32'h208, memw(B+32'h204),  B+32'h204,     1,0, 32'd10, 32'd5));

        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pcSrcE = 1'b0; pcTargetE = 32'd0;
        repeat (2) @(negedge clk);
        chk_all("reset", B, NOP, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            stallF = vecs[i].sf; stallD = vecs[i].sd; flushD = vecs[i].fd;
            pcSrcE = vecs[i].ps; pcTargetE = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].pcf, vecs[i].instr, vecs[i].pcd,
                    vecs[i].vld, vecs[i].mis, vecs[i].fc, vecs[i].rc);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a redirect, before any edge.
        pcSrcE = 1'b1; pcTargetE = B + 32'h300;
        #2 rst = 1'b1;
        #1 chk_all("async_rst", B, NOP, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 chk_all("rst_held", B, NOP, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0; pcSrcE = 1'b0; pcTargetE = 32'd0;
        @(posedge clk);
        #1 chk_all("post_rst", B + 32'h004, memw(B), B, 1'b1, 1'b0, 32'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32I core. It owns the PC register and drives the instruction memory's byte address. It takes the returned word back combinationally as instrF and registers it with its PC into the F/D pipeline register. It also handles load-use stalls, taken-branch/jump redirects from Execute, Decode flushes, and two fetch performance counters.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 32'hBFC00000, PC value after reset; base of instruction memory window
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stallF  in  1  hold PC (hazard unit, load-use)
stallD  in  1  hold F/D register
flushD  in  1  replace F/D contents with bubble
pcSrcE  in  1  taken branch/jump resolved in Execute
pcTargetE  in  XLEN  redirect target from Execute
pcF  out  XLEN  current fetch address, to instruction memory addr
instrF  in  32  instruction word from instruction memory (combinational on pcF)
instrD  out  32  registered instruction to Decode
pcD  out  XLEN  registered PC of instrD
pcPlus4D  out  XLEN  registered pcD+4
validD  out  1  instrD is a real fetched instruction (0 = bubble)
misalignD  out  1  redirect target had nonzero bits [1:0]
fetchCount  out  32  instructions delivered to Decode (validD rising into D)
redirectCount  out  32  number of cycles with pcSrcE=1

Behaviour:
- Reset (async, any cycle, including mid-stall/mid-redirect):
  - pcF=RESET_VECTOR; instrD=NOP_INSTR; pcD=0; pcPlus4D=0; validD=0; misalignD=0; both counters=0.
  - Reset release takes effect on the next rising edge; the first valid fetch is at RESET_VECTOR.
- pcPlus4F = pcF+4, modulo 2^XLEN (wrap 32'hFFFFFFFC -> 0, no flag).
- Next-PC priority, highest first:
  - pcSrcE=1: pcF <= {pcTargetE[XLEN-1:2],2'b00}. Redirect overrides stallF; a branch is never lost to a stall.
  - stallF=1: pcF holds.
  - else: pcF <= pcPlus4F.
- misalign: when pcSrcE=1 and pcTargetE[1:0]!=0, a pending flag is set. The flag travels with the first instruction fetched from the redirected PC into D (misalignD=1 for that one instruction only). It is cleared if that slot is flushed.
- F/D register priority, highest first:
  - flushD=1: instrD=NOP_INSTR, validD=0, pcD=0, pcPlus4D=0, misalignD=0. Flush overrides stallD.
  - stallD=1: all D outputs hold.
  - else: instrD<=instrF, pcD<=pcF, pcPlus4D<=pcPlus4F, validD<=1, misalignD<=pending flag.
- Latency: instruction at pcF appears on instrD exactly 1 cycle later when unstalled. A redirect in cycle N gives pcF=target in N+1 and instrD of target in N+2.
- Counters:
  - fetchCount increments on each edge where D loads a new instruction (not flush, not stall).
  - redirectCount increments on each edge with pcSrcE=1.
  - Both wrap at 2^32 silently and are not affected by stalls or flushes otherwise.
- Simultaneous pcSrcE+stallF+stallD+flushD: pcF<=target, D becomes bubble, redirectCount+1, fetchCount unchanged.
- No handshake with memory: instrF is assumed valid in the same cycle as pcF. Only pcF[11:0] is meaningful to the 4 KiB memory, but full XLEN is driven.

Decomposition:
- Shared package core_pkg:
  - constants RESET_VECTOR, NOP_INSTR;
  - typedef fd_reg_t struct {instr, pc, pcPlus4, valid, misalign};
  - the next-PC priority encoding as a localparam enum if the hazard unit reuses it.
- One sub-module is natural: fetch_pc_reg. It contains the PC register, next-PC mux, and misalign pending flag. fetch_stage instantiates it and adds the F/D register and counters.

Test Plan:
- Reset, release, 4 idle cycles with memory returning pc-dependent words -> pcF=BFC00000,04,08,0C,10. instrD follows one cycle late with pcPlus4D=pcD+4. validD=0 on the first cycle after reset, then 1. fetchCount=3 after cycle 4.
- stallF=stallD=1 for 2 cycles at pcF=BFC00008 -> pcF and all D outputs frozen. fetchCount unchanged. After release, fetching resumes at BFC0000C.
- pcSrcE=1, pcTargetE=BFC00100 for one cycle -> next pcF=BFC00100. Same-edge flushD=1 makes instrD=00000013, validD=0. Next cycle instrD=word@100. redirectCount=1.
- pcSrcE=1 with stallF=1 and pcTargetE=BFC00042 -> pcF=BFC00040. Redirect wins over the stall. misalignD=1 for exactly the instruction from BFC00040, 0 afterwards.
- flushD=1 and stallD=1 together -> bubble loaded (NOP, validD=0). Then assert rst mid-redirect -> all outputs return to reset values immediately, without waiting for a clock edge.
